sha1_core_par: RTL
==================

SHA1_CORE_PAR -- requirements
Module: sha1_core_par

Interface
REQ-001 Parameter UNROLL, default 1, SHA-1 rounds per clock; legal values 1,2,4,5,8,10,16,20 (divisors of 80); any other value SHALL fail elaboration.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to hash one 512-bit block; sampled only in IDLE.
REQ-005 use_prev_cv  input  1  at start: 1 = chain from internal cv_next register, 0 = chain from cv input.
REQ-006 data_i  input  512  message block, big-endian, W0 = data_i[511:480] ... W15 = data_i[31:0].
REQ-007 cv  input  160  external chaining value, H0 = cv[159:128] ... H4 = cv[31:0].
REQ-008 busy  output  1  high while a block is in progress.
REQ-009 out_valid  output  1  one-cycle pulse when cv_next holds a new digest.
REQ-010 cv_next  output  160  registered result, same word order as cv.

Function
REQ-011 FSM states SHALL be IDLE, ROUND, FINAL.
REQ-012 IDLE and start=1 at an edge: latch data_i into a 16-word schedule buffer, latch the chaining value selected by use_prev_cv into an internal H register and into A..E, clear the round counter, go to ROUND.
REQ-013 ROUND: each cycle SHALL perform UNROLL consecutive rounds t..t+UNROLL-1 with standard SHA-1 f/K per 20-round group, then advance t by UNROLL; after round 79, go to FINAL.
REQ-014 Schedule SHALL use a 16-word circular buffer: for t>=16, W[t] = ROTL1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), written in place at index t mod 16.
REQ-015 All additions SHALL be modulo 2^32.
REQ-016 FINAL: cv_next <= {H0+A, H1+B, H2+C, H3+D, H4+E}; out_valid=1 for the following cycle; go to IDLE.
REQ-017 busy SHALL be 1 in ROUND and FINAL and 0 in IDLE; busy rises the cycle after start is accepted.
REQ-018 Latency from accepting edge to out_valid high SHALL be 80/UNROLL+1 cycles (81 for UNROLL=1, 17 for UNROLL=5); busy falls in the same cycle out_valid rises.
REQ-019 start while busy SHALL be ignored; no queueing.
REQ-020 start asserted in the out_valid cycle SHALL be accepted (back-to-back blocks), and use_prev_cv=1 then chains the just-produced cv_next.
REQ-021 cv_next SHALL hold its value until the next FINAL; data_i and cv may change freely after the accepting edge.
REQ-022 use_prev_cv=1 before any completed block SHALL chain the reset value of cv_next.

Reset
REQ-023 rstn low SHALL force IDLE, busy=0, out_valid=0, cv_next=0, round counter=0, immediately and regardless of clock.
REQ-024 Reset mid-operation SHALL abandon the block with no out_valid pulse; after release the first start behaves as after power-up.

Configuration
REQ-025 Macro SHA1_CORE_PAR_ABORT_EN: when defined, add input abort (1 bit); abort=1 at an edge in ROUND or FINAL returns to IDLE with busy=0, no out_valid, cv_next unchanged; abort in IDLE has no effect, and abort wins over a FINAL update in the same cycle.
REQ-026 Without SHA1_CORE_PAR_ABORT_EN the abort port SHALL not exist and blocks always run to completion.

Verification
REQ-027 UNROLL=1, cv=67452301EFCDAB8998BADCFE10325476C3D2E1F0, data_i = padded "abc" (length 24 bits), use_prev_cv=0 -> cv_next=a9993e364706816aba3e25717850c26c9cd0d89d, out_valid exactly 81 cycles after start.
REQ-028 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with standard IV, block 2 (zeros, length 448) with use_prev_cv=1 -> 84983e441c3bd26ebaae4aa1f95129e5e54670f1.
REQ-029 REQ-027 and REQ-028 repeated for UNROLL=2,5,20 -> identical digests, latencies 41, 17, 5 cycles.
REQ-030 start pulsed at cycles 10 and 40 of an in-progress UNROLL=1 block -> single out_valid, digest unchanged from REQ-027.
REQ-031 rstn low at round 37 -> busy=0, cv_next=0 at once, no out_valid; subsequent "abc" block -> REQ-027 result.
REQ-032 With SHA1_CORE_PAR_ABORT_EN, abort at round 50 after a completed "abc" block -> busy=0 next cycle, no out_valid, cv_next still a9993e36...d89d.

Source files
------------

// File: rtl/sha1_core_par.sv
// sha1_core_par -- iterative SHA-1 compression core, UNROLL rounds per clock.
//
// Hashes one 512-bit block per start. The chaining value is taken from the
// cv input or from the core's own cv_next register, so multi-block messages
// can be chained with no external feedback path.
//
// Parameters
//   UNROLL       SHA-1 rounds per clock (1,2,4,5,8,10,16,20)
// Ports
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   start        hash request, sampled only when idle
//   use_prev_cv  1: chain from cv_next, 0: chain from cv
//   abort        (only with SHA1_CORE_PAR_ABORT_EN) drop the block in flight
//   data_i       message block, W0 in [511:480] ... W15 in [31:0]
//   cv           external chaining value, H0 in [159:128] ... H4 in [31:0]
//   busy         high while a block is in progress
//   out_valid    one-cycle pulse when cv_next holds a new digest
//   cv_next      registered digest, same word order as cv
//
// Optional feature: define SHA1_CORE_PAR_ABORT_EN to add the abort input.
module sha1_core_par #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         use_prev_cv,
`ifdef SHA1_CORE_PAR_ABORT_EN
  input  logic         abort,
`endif
  input  logic [511:0] data_i,
  input  logic [159:0] cv,
  output logic         busy,
  output logic         out_valid,
  output logic [159:0] cv_next
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5 ||
          UNROLL == 8 || UNROLL == 10 || UNROLL == 16 || UNROLL == 20)) begin : g_bad_unroll
      $error("sha1_core_par: UNROLL must divide 80 and be at most 20");
    end
  endgenerate

  localparam int LAST_T = 80 - UNROLL;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [6:0]    t_cnt;
  logic          abort_w;

  logic [31:0]   w_buf [16];
  logic [31:0]   w_nxt [16];
  logic [159:0]  h_reg;
  logic [31:0]   a, b, c, d, e;
  logic [31:0]   a_nxt, b_nxt, c_nxt, d_nxt, e_nxt;
  logic [6:0]    tj;
  logic [31:0]   wt;
  logic [31:0]   tmp;
  logic [159:0]  cv_sel;
  logic [159:0]  digest;

`ifdef SHA1_CORE_PAR_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

  function automatic logic [31:0] f_fn(input logic [6:0] t, input logic [31:0] x,
                                       input logic [31:0] y, input logic [31:0] z);
    if (t < 7'd20)      return (x & y) | (~x & z);
    else if (t < 7'd40) return x ^ y ^ z;
    else if (t < 7'd60) return (x & y) | (x & z) | (y & z);
    else                return x ^ y ^ z;
  endfunction

  function automatic logic [31:0] k_fn(input logic [6:0] t);
    if (t < 7'd20)      return 32'h5A827999;
    else if (t < 7'd40) return 32'h6ED9EBA1;
    else if (t < 7'd60) return 32'h8F1BBCDC;
    else                return 32'hCA62C1D6;
  endfunction

  assign busy   = (state != IDLE);
  assign cv_sel = use_prev_cv ? cv_next : cv;
  assign digest = {h_reg[159:128] + a, h_reg[127:96] + b, h_reg[95:64] + c,
                   h_reg[63:32] + d, h_reg[31:0] + e};

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ROUND;
      ROUND:   if (abort_w) state_nxt = IDLE;
               else if (t_cnt == 7'(LAST_T)) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers (reset)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_cnt     <= '0;
      out_valid <= 1'b0;
      cv_next   <= '0;
    end else begin
      out_valid <= (state == FINAL) && !abort_w;
      if (state == IDLE && start) t_cnt <= '0;
      else if (state == ROUND)    t_cnt <= t_cnt + 7'(UNROLL);
      // abort takes priority over the final update
      if (state == FINAL && !abort_w) cv_next <= digest;
    end
  end

  // UNROLL rounds per cycle. The schedule is expanded in place in a copy of
  // the circular buffer, in round order, so a word produced earlier in the
  // same cycle is visible to later rounds (including wrap-around when
  // UNROLL exceeds 16).
  always_comb begin
    w_nxt = w_buf;
    a_nxt = a;
    b_nxt = b;
    c_nxt = c;
    d_nxt = d;
    e_nxt = e;
    tj    = '0;
    wt    = '0;
    tmp   = '0;
    for (int j = 0; j < UNROLL; j++) begin
      tj = t_cnt + 7'(j);
      // the slot being overwritten still holds W[t-16]
      if (tj >= 7'd16)
        w_nxt[tj[3:0]] = rotl1(w_nxt[tj[3:0] - 4'd3] ^ w_nxt[tj[3:0] - 4'd8] ^
                               w_nxt[tj[3:0] - 4'd14] ^ w_nxt[tj[3:0]]);
      wt    = w_nxt[tj[3:0]];
      tmp   = rotl5(a_nxt) + f_fn(tj, b_nxt, c_nxt, d_nxt) + e_nxt + k_fn(tj) + wt;
      e_nxt = d_nxt;
      d_nxt = c_nxt;
      c_nxt = rotl30(b_nxt);
      b_nxt = a_nxt;
      a_nxt = tmp;
    end
  end

  // Datapath registers (no reset; loaded on every accepted start)
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < 16; i++) w_buf[i] <= data_i[511 - 32*i -: 32];
      h_reg <= cv_sel;
      a     <= cv_sel[159:128];
      b     <= cv_sel[127:96];
      c     <= cv_sel[95:64];
      d     <= cv_sel[63:32];
      e     <= cv_sel[31:0];
    end else if (state == ROUND) begin
      w_buf <= w_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      c     <= c_nxt;
      d     <= d_nxt;
      e     <= e_nxt;
    end
  end

endmodule
